// File: rtl/rvfi_commit_serializer.sv
// RVFI commit serializer.
// Collects up to NR_COMMIT_PORTS retirements per cycle from the core's RVFI
// bus into a small register FIFO. It replays them one per cycle, oldest first,
// on a valid/ready stream. Each entry is tagged with a 64-bit retirement
// sequence number. Entries that do not fit are dropped; the drop is recorded
// in a sticky overflow flag and a saturating drop counter.

package rvfi_pkg;

  // One retirement record as presented on each RVFI commit port.
  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [1:0]  mode;
    logic [1:0]  ixl;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [63:0] rs1_rdata;
    logic [63:0] rs2_rdata;
    logic [63:0] rd_wdata;
    logic [63:0] pc_rdata;
    logic [63:0] pc_wdata;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rmask;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;
    logic [63:0] mem_wdata;
  } rvfi_instr_t;

endpackage

module rvfi_commit_serializer #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0]  rvfi_i,
  output rvfi_pkg::rvfi_instr_t                        rvfi_o,
  output logic                                         valid_o,
  input  logic                                         ready_i,
  output logic [63:0]                                  order_o,
  output logic [$clog2(DEPTH+1)-1:0]                   count_o,
  output logic                                         overflow_o,
  output logic [31:0]                                  drop_cnt_o
);

  import rvfi_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  // A one-entry FIFO still needs a one-bit pointer; wrapping is done with an
  // explicit modulo so that case also stays correct.
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The payload is kept untouched; the sequence number travels beside it.
  typedef struct packed {
    rvfi_instr_t instr;
    logic [63:0] order;
  } entry_t;

  // Storage and pointers
  entry_t             mem_reg  [DEPTH];
  entry_t             mem_next [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [63:0]        seq_reg, seq_next;

  // Output-side registers
  rvfi_instr_t        rvfi_reg, rvfi_next;
  logic [63:0]        order_reg, order_next;
  logic               ovf_reg, ovf_next;
  logic [31:0]        drop_reg, drop_next;

  // Per-cycle push/pop bookkeeping
  logic [NR_COMMIT_PORTS-1:0] cand;
  logic [NR_COMMIT_PORTS-1:0] accept;
  logic [CNT_W-1:0]           cand_idx [NR_COMMIT_PORTS];
  logic [CNT_W-1:0]           n_cand;
  logic [CNT_W-1:0]           n_acc;
  logic [CNT_W-1:0]           n_drop;
  logic [CNT_W-1:0]           free_slots;
  logic                       pop;
  logic [32:0]                drop_sum;

  // Pointer advance with wrap modulo DEPTH.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                               input logic [CNT_W-1:0] inc);
    ptr_add = PTR_W'((32'(ptr) + 32'(inc)) % DEPTH);
  endfunction

  assign pop        = (count_reg != '0) && ready_i;
  assign free_slots = CNT_W'(DEPTH) - count_reg + CNT_W'(pop);

  // A port is a candidate when it reports a retirement or a trap. Because
  // accepted entries are always a prefix of the candidates, the candidate
  // index also serves as the slot offset and the sequence offset.
  for (genvar gi = 0; gi < NR_COMMIT_PORTS; gi++) begin : g_port
    assign cand[gi]   = rvfi_i[gi].valid | rvfi_i[gi].trap;
    assign accept[gi] = cand[gi] && (cand_idx[gi] < free_slots);
  end

  // Compress candidates in port order: index of each port among candidates.
  always_comb begin
    n_cand = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      cand_idx[p] = n_cand;
      n_cand      = n_cand + CNT_W'(cand[p]);
    end
  end

  // Accepted/dropped split: the oldest candidates win the free slots.
  always_comb begin
    n_acc  = (n_cand < free_slots) ? n_cand : free_slots;
    n_drop = n_cand - n_acc;
  end

  // Write accepted candidates into consecutive slots after the write pointer.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      mem_next[s] = mem_reg[s];
    end
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (accept[p]) begin
        mem_next[ptr_add(wr_ptr_reg, cand_idx[p])] =
          '{instr: rvfi_i[p], order: seq_reg + 64'(cand_idx[p])};
      end
    end
  end

  // Next pointers, occupancy, sequence counter and drop accounting.
  always_comb begin
    rd_ptr_next = pop ? ptr_add(rd_ptr_reg, CNT_W'(1)) : rd_ptr_reg;
    wr_ptr_next = ptr_add(wr_ptr_reg, n_acc);
    count_next  = count_reg - CNT_W'(pop) + n_acc;
    seq_next    = seq_reg + 64'(n_acc);
    ovf_next    = ovf_reg | (n_drop != '0);
    drop_sum    = {1'b0, drop_reg} + 33'(n_drop);
    drop_next   = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
  end

  // Present the entry that will be at the head after this edge; when the
  // FIFO goes empty the last head value is kept on the outputs.
  always_comb begin
    rvfi_next  = rvfi_reg;
    order_next = order_reg;
    if (count_next != '0) begin
      rvfi_next  = mem_next[rd_ptr_next].instr;
      order_next = mem_next[rd_ptr_next].order;
    end
  end

  // Payload storage; contents are only read when the slot is occupied.
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < DEPTH; s++) begin
      mem_reg[s] <= mem_next[s];
    end
  end

  // Control state and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      seq_reg    <= '0;
      rvfi_reg   <= '0;
      order_reg  <= '0;
      ovf_reg    <= 1'b0;
      drop_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      seq_reg    <= seq_next;
      rvfi_reg   <= rvfi_next;
      order_reg  <= order_next;
      ovf_reg    <= ovf_next;
      drop_reg   <= drop_next;
    end
  end

  assign rvfi_o     = rvfi_reg;
  assign order_o    = order_reg;
  assign valid_o    = (count_reg != '0);
  assign count_o    = count_reg;
  assign overflow_o = ovf_reg;
  assign drop_cnt_o = drop_reg;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Directed bench for rvfi_commit_serializer (NR_COMMIT_PORTS=2, DEPTH=8).
// A vector table drives one cycle per record and checks the registered state
// after the edge; the asynchronous reset case is a hand-written sequence.
module tb_rvfi_commit_serializer;
  import rvfi_pkg::*;

  localparam int NR    = 2;
  localparam int DEPTH = 8;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  rvfi_instr_t [NR-1:0] rvfi_i;
  rvfi_instr_t          rvfi_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [63:0]          order_o;
  logic [3:0]           count_o;
  logic                 overflow_o;
  logic [31:0]          drop_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  rvfi_commit_serializer #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rvfi_i     (rvfi_i),
    .rvfi_o     (rvfi_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .order_o    (order_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Build a recognisable payload from a pc so the whole record can be checked.
  function automatic rvfi_instr_t mk(input logic v, input logic t, input logic [63:0] pc);
    rvfi_instr_t r;
    r          = '0;
    r.valid    = v;
    r.trap     = t;
    r.pc_rdata = pc;
    r.pc_wdata = pc + 64'd4;
    r.insn     = pc[31:0] ^ 32'h0000_0013;
    r.rd_wdata = {pc[31:0], ~pc[31:0]};
    r.mode     = 2'd3;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_payload(input string nm, input rvfi_instr_t act, input rvfi_instr_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got pc=%0h v=%0b trap=%0b expected pc=%0h v=%0b trap=%0b",
               nm, act.pc_rdata, act.valid, act.trap, exp.pc_rdata, exp.valid, exp.trap);
    end
  endtask

  typedef struct {
    logic        v0, t0;
    logic [63:0] pc0;
    logic        v1, t1;
    logic [63:0] pc1;
    logic        rdy;
    logic        e_valid;
    int          e_count;
    logic [63:0] e_order;
    logic        e_pv, e_trap;
    logic [63:0] e_pc;
    logic        e_ovf;
    int          e_drop;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic v0, input logic t0, input logic [63:0] pc0,
                     input logic v1, input logic t1, input logic [63:0] pc1,
                     input logic rdy, input logic ev, input int ec,
                     input logic [63:0] eo, input logic epv, input logic etr,
                     input logic [63:0] epc, input logic eovf, input int edrop);
    vec_t v;
    v = '{v0, t0, pc0, v1, t1, pc1, rdy, ev, ec, eo, epv, etr, epc, eovf, edrop};
    vq.push_back(v);
  endtask

  localparam logic [63:0] JUNK = 64'hDEAD_0000;

  initial begin
    rst_ni  = 1'b0;
    rvfi_i  = '0;
    ready_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_order", order_o, 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    chk_payload("rst_rvfi", rvfi_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    //  v0 t0 pc0            v1 t1 pc1            rdy | valid cnt order pv trap pc           ovf drop
    // two ports, pop both
    add(1, 0, 64'h8000_0000, 1, 0, 64'h8000_0004, 1,  1, 2, 0,  1, 0, 64'h8000_0000, 0, 0);
    add(0, 0, JUNK,          0, 0, JUNK,          1,  1, 1, 1,  1, 0, 64'h8000_0004, 0, 0);
    add(0, 0, JUNK,          0, 0, JUNK,          1,  0, 0, 0,  0, 0, 64'h0,         0, 0);
    // port 0 idle, port 1 valid: no gap
    add(0, 0, JUNK,          1, 0, 64'h100,       0,  1, 1, 2,  1, 0, 64'h100,       0, 0);
    add(0, 0, JUNK,          0, 0, JUNK,          1,  0, 0, 0,  0, 0, 64'h0,         0, 0);
    // trap-only retirement is enqueued
    add(0, 1, 64'h200,       0, 0, JUNK,          0,  1, 1, 3,  0, 1, 64'h200,       0, 0);
    add(0, 0, JUNK,          0, 0, JUNK,          1,  0, 0, 0,  0, 0, 64'h0,         0, 0);
    // fill without pops, then overflow drops both
    add(1, 0, 64'h1000,      1, 0, 64'h1004,      0,  1, 2, 4,  1, 0, 64'h1000,      0, 0);
    add(1, 0, 64'h1008,      1, 0, 64'h100c,      0,  1, 4, 4,  1, 0, 64'h1000,      0, 0);
    add(1, 0, 64'h1010,      1, 0, 64'h1014,      0,  1, 6, 4,  1, 0, 64'h1000,      0, 0);
    add(1, 0, 64'h1018,      1, 0, 64'h101c,      0,  1, 8, 4,  1, 0, 64'h1000,      0, 0);
    add(1, 0, 64'h1020,      1, 0, 64'h1024,      0,  1, 8, 4,  1, 0, 64'h1000,      1, 2);
    // full with pop: one candidate fits, the second of two is dropped
    add(1, 0, 64'h2000,      0, 0, JUNK,          1,  1, 8, 5,  1, 0, 64'h1004,      1, 2);
    add(1, 0, 64'h2004,      1, 0, 64'h2008,      1,  1, 8, 6,  1, 0, 64'h1008,      1, 3);
    // drain; dropped entries consumed no sequence numbers
    add(0, 0, JUNK,          0, 0, JUNK,          1,  1, 7, 7,  1, 0, 64'h100c,      1, 3);
    add(0, 0, JUNK,          0, 0, JUNK,          1,  1, 6, 8,  1, 0, 64'h1010,      1, 3);
    add(0, 0, JUNK,          0, 0, JUNK,          1,  1, 5, 9,  1, 0, 64'h1014,      1, 3);
    add(0, 0, JUNK,          0, 0, JUNK,          1,  1, 4, 10, 1, 0, 64'h1018,      1, 3);
    add(0, 0, JUNK,          0, 0, JUNK,          1,  1, 3, 11, 1, 0, 64'h101c,      1, 3);
    add(0, 0, JUNK,          0, 0, JUNK,          1,  1, 2, 12, 1, 0, 64'h2000,      1, 3);
    add(0, 0, JUNK,          0, 0, JUNK,          1,  1, 1, 13, 1, 0, 64'h2004,      1, 3);
    add(0, 0, JUNK,          0, 0, JUNK,          1,  0, 0, 0,  0, 0, 64'h0,         1, 3);
    // after drops the next accepted entry continues the sequence
    add(0, 0, JUNK,          1, 0, 64'h3000,      0,  1, 1, 14, 1, 0, 64'h3000,      1, 3);
    add(1, 0, 64'h3004,      0, 1, 64'h3008,      1,  1, 2, 15, 1, 0, 64'h3004,      1, 3);
    add(0, 0, JUNK,          0, 0, JUNK,          0,  1, 2, 15, 1, 0, 64'h3004,      1, 3);
    add(0, 0, JUNK,          0, 0, JUNK,          1,  1, 1, 16, 0, 1, 64'h3008,      1, 3);
    add(0, 0, JUNK,          0, 0, JUNK,          1,  0, 0, 0,  0, 0, 64'h0,         1, 3);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk_i);
      rvfi_i[0] = mk(vq[i].v0, vq[i].t0, vq[i].pc0);
      rvfi_i[1] = mk(vq[i].v1, vq[i].t1, vq[i].pc1);
      ready_i   = vq[i].rdy;
      @(posedge clk_i);
      #1;
      $display("[TB] vec %0d: valid=%0b count=%0d order=%0d pc=%0h ovf=%0b drop=%0d",
               i, valid_o, count_o, order_o, rvfi_o.pc_rdata, overflow_o, drop_cnt_o);
      chk($sformatf("vec%0d_count", i), 64'(count_o), 64'(vq[i].e_count));
      chk($sformatf("vec%0d_valid", i), 64'(valid_o), 64'(vq[i].e_valid));
      chk($sformatf("vec%0d_ovf", i), 64'(overflow_o), 64'(vq[i].e_ovf));
      chk($sformatf("vec%0d_drop", i), 64'(drop_cnt_o), 64'(vq[i].e_drop));
      if (vq[i].e_valid) begin
        chk($sformatf("vec%0d_order", i), order_o, vq[i].e_order);
        chk_payload($sformatf("vec%0d_rvfi", i), rvfi_o,
                    mk(vq[i].e_pv, vq[i].e_trap, vq[i].e_pc));
      end
    end

    // Asynchronous reset mid-stream: build count=5 with overflow still set.
    @(negedge clk_i);
    rvfi_i[0] = mk(1, 0, 64'h4000);
    rvfi_i[1] = mk(1, 0, 64'h4004);
    ready_i   = 1'b0;
    @(negedge clk_i);
    rvfi_i[0] = mk(1, 0, 64'h4008);
    rvfi_i[1] = mk(1, 0, 64'h400c);
    @(negedge clk_i);
    rvfi_i[0] = mk(1, 0, 64'h4010);
    rvfi_i[1] = mk(0, 0, JUNK);
    @(negedge clk_i);
    rvfi_i[0] = mk(0, 0, JUNK);
    $display("[TB] pre-reset: count=%0d ovf=%0b drop=%0d", count_o, overflow_o, drop_cnt_o);
    chk("pre_rst_count", 64'(count_o), 64'd5);
    chk("pre_rst_ovf", 64'(overflow_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    $display("[TB] async reset: count=%0d valid=%0b ovf=%0b drop=%0d", count_o, valid_o, overflow_o, drop_cnt_o);
    chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_ovf", 64'(overflow_o), 64'd0);
    chk("arst_drop", 64'(drop_cnt_o), 64'd0);
    chk("arst_order", order_o, 64'd0);
    @(negedge clk_i);
    rst_ni    = 1'b1;
    rvfi_i[0] = mk(1, 0, 64'h5000);
    @(posedge clk_i);
    #1;
    $display("[TB] post-reset push: count=%0d order=%0d pc=%0h", count_o, order_o, rvfi_o.pc_rdata);
    chk("post_rst_count", 64'(count_o), 64'd1);
    chk("post_rst_order", order_o, 64'd0);
    chk_payload("post_rst_rvfi", rvfi_o, mk(1, 0, 64'h5000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rvfi_commit_serializer.md
Name: rvfi_commit_serializer

Overview:
- Sits directly upstream of the per-hart RVFI trace/termination logic in the testbench.
- Takes the NR_COMMIT_PORTS-wide RVFI commit bus from the core and buffers each cycle's retirements in a FIFO.
- Emits them one per cycle, in program order, on a single-port valid/ready stream, tagged with a 64-bit retirement sequence number.
- Lets single-port consumers (trace writers, DPI checkers) see a strictly ordered stream, with overflow detection and drop counting.

Parameters:
- NR_COMMIT_PORTS, 2, number of RVFI commit ports sampled per cycle (1..4).
- DEPTH, 8, FIFO entries. Power of two, >= NR_COMMIT_PORTS.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- rvfi_i  input  NR_COMMIT_PORTS x $bits(rvfi_pkg::rvfi_instr_t)  commit bus; port 0 is oldest
- rvfi_o  output  $bits(rvfi_pkg::rvfi_instr_t)  head entry
- valid_o  output  1  head entry valid
- ready_i  input  1  consumer accepts head this cycle
- order_o  output  64  sequence number of head entry
- count_o  output  $clog2(DEPTH+1)  current occupancy
- overflow_o  output  1  sticky; set when any entry is dropped
- drop_cnt_o  output  32  saturating count of dropped entries

Behaviour:
- Reset: asynchronous, active-low, single clock clk_i. While rst_ni is low, and immediately on assertion mid-operation:
  - FIFO flushed; count_o=0, valid_o=0.
  - rvfi_o='0, order_o=0.
  - overflow_o=0, drop_cnt_o=0; internal sequence counter=0.
- Push qualification: port i is a candidate when rvfi_i[i].valid || rvfi_i[i].trap. Candidates are compressed in port order (port 0 first); non-candidate ports create no gaps.
- Pop: occurs when valid_o && ready_i. ready_i while valid_o=0 has no effect.
- Free slots this cycle: free = DEPTH - count + (pop ? 1 : 0). Pop and push in the same cycle are both honoured.
- Acceptance: the first min(ncand, free) candidates in port order are written. The remaining candidates are dropped:
  - overflow_o <= 1, and stays set until reset;
  - drop_cnt_o += dropped count, saturating at 32'hFFFF_FFFF.
- Sequencing: each accepted entry stores seq + k, where k is its index among accepted entries this cycle (0-based). seq then advances by the accepted count. Dropped entries do not consume sequence numbers. The 64-bit counter wraps modulo 2^64.
- Latency: no fall-through. An entry pushed at edge N is visible on rvfi_o/order_o/valid_o after edge N, i.e. earliest pop in cycle N+1.
- Output registers and pointers:
  - rvfi_o/order_o show the head entry; they are held stable while valid_o && !ready_i.
  - When empty, rvfi_o and order_o hold their last value; consumers must ignore them while valid_o=0.
  - count_o = entries stored, registered. Pointers wrap modulo DEPTH.
- Full with pop: count=DEPTH, pop=1, one candidate gives free=1, so the candidate is accepted with no drop.
- Full without pop: every candidate is dropped.
- Storage: registers only, no SRAM; payload is stored unmodified.

Test Plan:
- Reset, then 2 ports valid at cycle 1 (pc 0x80000000, 0x80000004), ready_i=1 -> valid_o from cycle 2. Pops in cycles 2 and 3 give order_o=0 then 1 and the matching PCs; count_o is 2, then 1, then 0.
- Port 0 invalid, port 1 valid with pc 0x100 -> one entry with order 0; no gap.
- Port 0 with trap=1, valid=0, pc 0x200 -> entry is enqueued and passed through with trap=1.
- ready_i=0 with both ports valid for 5 cycles at DEPTH=8 -> after 4 cycles count_o=8. Cycle 5 drops 2: overflow_o=1, drop_cnt_o=2. The next order_o values after draining are 0..7, and the following accepted entry gets order 8.
- Full FIFO with ready_i=1 and one port valid -> simultaneous pop/push, count stays 8, no drop; with two ports valid -> 1 accepted, drop_cnt_o+=1.
- Assert rst_ni low mid-stream with count_o=5 and overflow_o=1 -> asynchronously count_o=0, valid_o=0, overflow_o=0, drop_cnt_o=0; the next accepted entry has order_o=0.
